// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronised input, edge-aligned oversampling, and a 3-sample majority vote per bit.
// The frame is reported in the middle of the stop bit so that back-to-back frames can resync early.
`timescale 1ns/1ps
module uart_rx_8n1 #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          r_state, w_state_next;
  logic            r_sync1, r_sync2, r_line_prev;
  logic [TW-1:0]   r_tick_cnt;
  logic [SW-1:0]   r_s;
  logic [2:0]      r_bit_idx;
  logic            r_samp_a, r_samp_b;
  logic [7:0]      r_shift;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid, r_rx_frame_err;

  logic w_tick, w_fall, w_mid, w_end, w_majority;
  logic w_start_det, w_to_data, w_shift, w_valid_set, w_err_set;

  assign w_tick     = (r_tick_cnt == TW'(DIV - 1));
  assign w_fall     = r_line_prev & ~r_sync2;
  assign w_mid      = w_tick && (r_s == SW'(M + 1));
  assign w_end      = w_tick && (r_s == SW'(OVERSAMPLE - 1));
  assign w_majority = (r_samp_a & r_samp_b) | (r_samp_a & r_sync2) | (r_samp_b & r_sync2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_line_prev <= 1'b1;
    end else begin
      r_sync1     <= uart_rx;
      r_sync2     <= r_sync1;
      r_line_prev <= r_sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start_det  = 1'b0;
    w_to_data    = 1'b0;
    w_shift      = 1'b0;
    w_valid_set  = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_next = START;
          w_start_det  = 1'b1;
        end
      end
      START: begin
        // A start bit that votes high was only a glitch on an idle line.
        if (w_mid && w_majority) begin
          w_state_next = IDLE;
        end else if (w_end) begin
          w_state_next = DATA;
          w_to_data    = 1'b1;
        end
      end
      DATA: begin
        w_shift = w_mid;
        if (w_end && (r_bit_idx == 3'd7)) w_state_next = STOP;
      end
      STOP: begin
        if (w_mid) begin
          w_state_next = IDLE;
          w_valid_set  = w_majority;
          w_err_set    = ~w_majority;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt     <= '0;
      r_s            <= '0;
      r_bit_idx      <= '0;
      r_samp_a       <= 1'b1;
      r_samp_b       <= 1'b1;
      r_shift        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rx_frame_err <= 1'b0;
    end else begin
      // Restarting both counters on the edge puts the votes at mid-bit.
      if (w_start_det || w_tick) r_tick_cnt <= '0;
      else                       r_tick_cnt <= r_tick_cnt + 1'b1;

      if (w_start_det)  r_s <= '0;
      else if (w_tick)  r_s <= w_end ? '0 : r_s + 1'b1;

      if (w_tick && (r_s == SW'(M - 1))) r_samp_a <= r_sync2;
      if (w_tick && (r_s == SW'(M)))     r_samp_b <= r_sync2;

      if (w_start_det || w_to_data)        r_bit_idx <= '0;
      else if ((r_state == DATA) && w_end) r_bit_idx <= r_bit_idx + 1'b1;

      if (w_shift)     r_shift   <= {w_majority, r_shift[7:1]};
      if (w_valid_set) r_rx_data <= r_shift;

      r_rx_valid     <= w_valid_set;
      r_rx_frame_err <= w_err_set;
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_frame_err = r_rx_frame_err;
  assign rx_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1 at 160 clk per bit (DIV=10, OVERSAMPLE=16).
// A negedge monitor logs pulses; the main sequence drives frames and checks the log.
`timescale 1ns/1ps
module tb_uart_rx_8n1;

  logic       clk = 1'b0;
  logic       rst;
  logic       line;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_busy;

  int n_vec = 0;
  int n_err = 0;

  int         valid_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0, busy_cycles = 0;
  logic       prev_v = 1'b0, prev_e = 1'b0;
  logic [7:0] rx_log [0:63];

  uart_rx_8n1 #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .uart_rx(line),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_log[valid_cnt % 64] <= rx_data;
      valid_cnt <= valid_cnt + 1;
    end
    if (rx_frame_err === 1'b1) err_cnt <= err_cnt + 1;
    if (rx_valid === 1'b1 && rx_frame_err === 1'b1) both_cnt <= both_cnt + 1;
    if ((rx_valid === 1'b1 && prev_v) || (rx_frame_err === 1'b1 && prev_e)) wide_cnt <= wide_cnt + 1;
    if (rx_busy === 1'b1) busy_cycles <= busy_cycles + 1;
    prev_v <= (rx_valid === 1'b1);
    prev_e <= (rx_frame_err === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    line = v;
    repeat (n) @(negedge clk);
  endtask

  // Frame bits: 0=start, 1..8=data LSB first, 9=stop; optional inversion window inside one bit.
  task automatic send_frame(input logic [7:0] d, input int cpb, input logic stop_v,
                            input int gbit, input int gstart, input int glen);
    logic [9:0] bits;
    bits = {stop_v, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < cpb; c++) begin
        line = bits[b] ^ ((b == gbit) && (c >= gstart) && (c < gstart + glen));
        @(negedge clk);
      end
    end
    line = 1'b1;
  endtask

  int v0, e0, b0;

  initial begin
    rst  = 1'b1;
    line = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  {24'd0, rx_data}, 32'h00);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_err",   {31'd0, rx_frame_err}, 32'd0);
    check("rst_busy",  {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    hold(1'b1, 40);
    check("idle_busy", {31'd0, rx_busy}, 32'd0);

    // 1: single frame at exact baud
    v0 = valid_cnt; e0 = err_cnt; b0 = busy_cycles;
    send_frame(8'h2A, 160, 1'b1, -1, 0, 0);
    hold(1'b1, 160);
    check("t1_count", valid_cnt - v0, 32'd1);
    check("t1_data",  {24'd0, rx_log[v0 % 64]}, 32'h2A);
    check("t1_err",   err_cnt - e0, 32'd0);
    check("t1_busy_cycles", busy_cycles - b0, 32'd1540);

    // 2: 30-clk low glitch on idle line
    v0 = valid_cnt; e0 = err_cnt;
    hold(1'b0, 20);
    check("t2_busy_in_glitch", {31'd0, rx_busy}, 32'd1);
    hold(1'b0, 10);
    hold(1'b1, 160);
    check("t2_busy_after", {31'd0, rx_busy}, 32'd0);
    check("t2_no_valid", valid_cnt - v0, 32'd0);
    check("t2_no_err",   err_cnt - e0, 32'd0);
    send_frame(8'h55, 160, 1'b1, -1, 0, 0);
    hold(1'b1, 160);
    check("t2_count", valid_cnt - v0, 32'd1);
    check("t2_data",  {24'd0, rx_log[v0 % 64]}, 32'h55);

    // 3: framing error, then line stuck low, then recovery
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hA5, 160, 1'b0, -1, 0, 0);
    hold(1'b0, 320);
    check("t3_err",        err_cnt - e0, 32'd1);
    check("t3_no_valid",   valid_cnt - v0, 32'd0);
    check("t3_data_kept",  {24'd0, rx_data}, 32'h55);
    check("t3_busy_low",   {31'd0, rx_busy}, 32'd0);
    hold(1'b1, 160);
    send_frame(8'h3C, 160, 1'b1, -1, 0, 0);
    hold(1'b1, 160);
    check("t3_err_total", err_cnt - e0, 32'd1);
    check("t3_count",     valid_cnt - v0, 32'd1);
    check("t3_data",      {24'd0, rx_log[v0 % 64]}, 32'h3C);

    // 4: back-to-back frames, transmitter 2% fast (157) then 2% slow (163)
    for (int k = 0; k < 2; k++) begin
      int cpb;
      cpb = (k == 0) ? 157 : 163;
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h00, cpb, 1'b1, -1, 0, 0);
      send_frame(8'hFF, cpb, 1'b1, -1, 0, 0);
      send_frame(8'h81, cpb, 1'b1, -1, 0, 0);
      hold(1'b1, 320);
      check($sformatf("t4_%0d_count", cpb), valid_cnt - v0, 32'd3);
      check($sformatf("t4_%0d_err", cpb),   err_cnt - e0, 32'd0);
      check($sformatf("t4_%0d_d0", cpb), {24'd0, rx_log[v0 % 64]}, 32'h00);
      check($sformatf("t4_%0d_d1", cpb), {24'd0, rx_log[(v0 + 1) % 64]}, 32'hFF);
      check($sformatf("t4_%0d_d2", cpb), {24'd0, rx_log[(v0 + 2) % 64]}, 32'h81);
    end

    // 5: inverted pulse over the middle vote of data bit 2 (frame bit 3)
    v0 = valid_cnt;
    send_frame(8'h0F, 160, 1'b1, 3, 85, 10);
    hold(1'b1, 160);
    check("t5_count", valid_cnt - v0, 32'd1);
    check("t5_data",  {24'd0, rx_log[v0 % 64]}, 32'h0F);

    // 6: asynchronous reset during data bit 4 of 0xC3, held until line idles
    v0 = valid_cnt; e0 = err_cnt;
    hold(1'b0, 160);
    for (int i = 0; i < 4; i++) hold(((8'hC3 >> i) & 8'h01) != 0, 160);
    hold(1'b0, 80);
    check("t6_busy_pre",  {31'd0, rx_busy}, 32'd1);
    check("t6_data_pre",  {24'd0, rx_data}, 32'h0F);
    #3 rst = 1'b1;
    #1;
    check("t6_async_busy", {31'd0, rx_busy}, 32'd0);
    check("t6_async_data", {24'd0, rx_data}, 32'h00);
    @(negedge clk);
    hold(1'b0, 79);
    hold(1'b0, 160);
    hold(1'b1, 480);
    rst = 1'b0;
    hold(1'b1, 160);
    check("t6_no_valid", valid_cnt - v0, 32'd0);
    check("t6_no_err",   err_cnt - e0, 32'd0);
    send_frame(8'h96, 160, 1'b1, -1, 0, 0);
    hold(1'b1, 160);
    check("t6_count", valid_cnt - v0, 32'd1);
    check("t6_data",  {24'd0, rx_log[v0 % 64]}, 32'h96);

    check("pulse_overlap", both_cnt, 32'd0);
    check("pulse_width",   wide_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
